mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the CPU instruction-fetch port and the data load/store port.
- Lets the core run against a single-port memory instead of the dual-port RAM.
- Sits between the cpu core and the memory. Grants at most one access per cycle and routes the read response back to the owning requester.
- Memory read latency is fixed at 1 cycle: the address is presented in cycle N and read data is valid in cycle N+1.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory signals around mem_port_arbiter.
// master = core + memory side, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_wr;
  logic [31:0]   m_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wdata, m_wr
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_wdata, m_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 1-cycle-latency RAM between the fetch and data ports.
// Optional starvation guard for the losing port: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int DATA_PRIO  = 1,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    RESP_NONE   = 2'd0,
    RESP_IFETCH = 2'd1,
    RESP_DLOAD  = 2'd2
  } resp_sel_t;

  resp_sel_t     resp_sel_reg, resp_sel_next;
  logic          i_gnt, d_gnt;
  logic          data_wins;
  logic [AW-1:0] m_addr_sel;
  logic [AW-1:0] addr_hold_reg;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             starve_force;
  logic             np_req, np_gnt;

  assign np_req       = (DATA_PRIO != 0) ? bus.i_req : bus.d_req;
  assign np_gnt       = (DATA_PRIO != 0) ? i_gnt : d_gnt;
  assign starve_force = (starve_cnt_reg == CNT_W'(STARVE_MAX));
  // The forced grant clears the count, so it never runs past STARVE_MAX.
  assign data_wins    = (DATA_PRIO != 0) ^ starve_force;

  always_comb begin
    starve_cnt_next = '0;
    if (np_req && !np_gnt) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  assign data_wins = (DATA_PRIO != 0);
`endif

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (bus.d_req && (!bus.i_req || data_wins)) begin
        d_gnt = 1'b1;
      end else if (bus.i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Idle cycles keep the last address on the bus to avoid needless toggling.
  always_comb begin
    m_addr_sel = addr_hold_reg;
    if (d_gnt) begin
      m_addr_sel = bus.d_addr;
    end else if (i_gnt) begin
      m_addr_sel = bus.i_addr;
    end
  end

  always_ff @(posedge clk) begin
    addr_hold_reg <= m_addr_sel;
  end

  assign bus.i_gnt   = i_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.m_addr  = m_addr_sel;
  assign bus.m_wdata = bus.d_wdata;
  assign bus.m_wr    = d_gnt & bus.d_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_sel_reg <= RESP_NONE;
    end else begin
      resp_sel_reg <= resp_sel_next;
    end
  end

  always_comb begin
    resp_sel_next = RESP_NONE;
    if (i_gnt) begin
      resp_sel_next = RESP_IFETCH;
    end else if (d_gnt && !bus.d_we) begin
      resp_sel_next = RESP_DLOAD;
    end
  end

  always_comb begin
    bus.i_rvalid = (resp_sel_reg == RESP_IFETCH);
    bus.d_rvalid = (resp_sel_reg == RESP_DLOAD);
    bus.i_rdata  = bus.m_rdata;
    bus.d_rdata  = bus.m_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first 1-cycle-latency RAM model.
// Expected starvation pattern follows ARB_STARVE_GUARD_EN if it is defined for the build.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32)) bus ();

  mem_port_arbiter #(
      .DATA_PRIO (1),
      .STARVE_MAX(STARVE_MAX),
      .AW        (32)
  ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
  );

  logic [31:0] mem [0:1023];

  // Preload happens while reset is held so the memory has a single writer.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
      mem[10'h040] <= 32'h0050_0093;
      mem[10'h041] <= 32'h1111_1111;
      mem[10'h080] <= 32'hDEAD_BEEF;
      mem[10'h000] <= 32'hA000_0000;
      mem[10'h001] <= 32'hA000_0001;
      mem[10'h002] <= 32'hA000_0002;
      bus.m_rdata  <= 32'h0;
    end else begin
      if (bus.m_wr) mem[bus.m_addr[11:2]] <= bus.m_wdata;
      bus.m_rdata <= bus.m_wr ? bus.m_wdata : mem[bus.m_addr[11:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  initial begin
    logic exp_i, prev_i;
    rst_n       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;

    // Reset: requests present but everything held off.
    repeat (3) @(negedge clk);
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
    #1;
    chk("rst_i_gnt", bus.i_gnt, 1'b0);
    chk("rst_d_gnt", bus.d_gnt, 1'b0);
    chk("rst_m_wr", bus.m_wr, 1'b0);
    chk("rst_i_rvalid", bus.i_rvalid, 1'b0);
    chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    #1;
    chk("f1_i_gnt", bus.i_gnt, 1'b1);
    chk("f1_d_gnt", bus.d_gnt, 1'b0);
    chk("f1_m_addr", bus.m_addr, 32'h100);
    chk("f1_m_wr", bus.m_wr, 1'b0);
    @(negedge clk);
    bus.i_req = 1'b0;
    #1;
    chk("f1_i_rvalid", bus.i_rvalid, 1'b1);
    chk("f1_i_rdata", bus.i_rdata, 32'h0050_0093);
    chk("f1_d_rvalid", bus.d_rvalid, 1'b0);
    chk("f1_idle_m_addr", bus.m_addr, 32'h100);
    @(negedge clk);
    #1;
    chk("f1_i_rvalid_end", bus.i_rvalid, 1'b0);

    // Conflict: data port wins, fetch follows.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    #1;
    chk("c_d_gnt", bus.d_gnt, 1'b1);
    chk("c_i_gnt", bus.i_gnt, 1'b0);
    chk("c_m_addr", bus.m_addr, 32'h200);
    @(negedge clk);
    bus.d_req = 1'b0;
    #1;
    chk("c_d_rvalid", bus.d_rvalid, 1'b1);
    chk("c_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    chk("c_i_gnt2", bus.i_gnt, 1'b1);
    chk("c_m_addr2", bus.m_addr, 32'h104);
    @(negedge clk);
    bus.i_req = 1'b0;
    #1;
    chk("c_i_rvalid", bus.i_rvalid, 1'b1);
    chk("c_i_rdata", bus.i_rdata, 32'h1111_1111);
    chk("c_d_rvalid2", bus.d_rvalid, 1'b0);

    // Store then load same address.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_wdata = 32'h1234_5678;
    #1;
    chk("s_d_gnt", bus.d_gnt, 1'b1);
    chk("s_m_wr", bus.m_wr, 1'b1);
    chk("s_m_wdata", bus.m_wdata, 32'h1234_5678);
    @(negedge clk);
    bus.d_we = 1'b0;
    #1;
    chk("l_d_gnt", bus.d_gnt, 1'b1);
    chk("l_m_wr", bus.m_wr, 1'b0);
    chk("s_no_rvalid", bus.d_rvalid, 1'b0);
    @(negedge clk);
    bus.d_req = 1'b0;
    #1;
    chk("l_d_rvalid", bus.d_rvalid, 1'b1);
    chk("l_d_rdata", bus.d_rdata, 32'h1234_5678);
    chk("l_m_wr_idle", bus.m_wr, 1'b0);

    // Back-to-back fetches 0x0, 0x4, 0x8.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.i_req  = (k < 3);
      bus.i_addr = 32'(4 * k);
      #1;
      chk($sformatf("b2b%0d_i_gnt", k), bus.i_gnt, (k < 3));
      chk($sformatf("b2b%0d_i_rvalid", k), bus.i_rvalid, (k > 0));
      if (k > 0) chk($sformatf("b2b%0d_i_rdata", k), bus.i_rdata, 32'hA000_0000 + 32'(k - 1));
    end

    // Reset while a fetch is being granted: its response must be dropped.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    #1;
    chk("r_i_gnt", bus.i_gnt, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("r_i_gnt_rst", bus.i_gnt, 1'b0);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
    #1;
    chk("r_i_rvalid", bus.i_rvalid, 1'b0);
    chk("r_d_gnt", bus.d_gnt, 1'b0);
    chk("r_m_wr", bus.m_wr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.i_addr = 32'h8;
    #1;
    chk("r_i_rvalid2", bus.i_rvalid, 1'b0);
    chk("r_rel_i_gnt", bus.i_gnt, 1'b1);
    @(negedge clk);
    bus.i_req = 1'b0;
    #1;
    chk("r_rel_i_rvalid", bus.i_rvalid, 1'b1);
    chk("r_rel_i_rdata", bus.i_rdata, 32'hA000_0002);

    // Both ports held continuously.
    prev_i = 1'b0;
    for (int c = 0; c < 2 * (STARVE_MAX + 1); c++) begin
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = 32'h104;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
`ifdef ARB_STARVE_GUARD_EN
      exp_i = ((c % (STARVE_MAX + 1)) == STARVE_MAX);
`else
      exp_i = 1'b0;
`endif
      #1;
      chk($sformatf("st%0d_i_gnt", c), bus.i_gnt, exp_i);
      chk($sformatf("st%0d_d_gnt", c), bus.d_gnt, !exp_i);
      if (c > 0) chk($sformatf("st%0d_i_rvalid", c), bus.i_rvalid, prev_i);
      prev_i = exp_i;
    end
    @(negedge clk);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    #1;
    chk("st_end_i_rvalid", bus.i_rvalid, prev_i);
    chk("st_end_d_rvalid", bus.d_rvalid, !prev_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
